seg_display_arbiter: RTL
========================

# seg_display_arbiter

Round-robin arbiter that shares the board's single 7-segment display (`SEG`) among up to `NREQ` requesters, such as the hex up/down counter and the serial-sequence detector. Each requester holds a request together with a 4-bit value. The arbiter grants one requester at a time, latches its nibble, and shows the hex glyph on `SEG` for a fixed `HOLD` cycles. It then pulses a per-requester `done` and re-arbitrates. It sits between the `top` datapath blocks and the `SEG` output pins.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `HOLD`, default 4: display cycles per grant, ≥1.
- `clk_2`, input, 1 bit: system clock; all state is updated on the rising edge.
- `reset_n`, input, 1 bit: asynchronous, active-low reset.
- `req`, input, `NREQ` bits: `req[i]` high means requester i wants the display.
- `data`, input, `4*NREQ` bits: requester i's nibble is `data[4i+3:4i]`; it must be stable while `req[i]` is high and not yet granted.
- `gnt`, output, `NREQ` bits: one-hot; high for the whole SHOW period of the granted requester.
- `done`, output, `NREQ` bits: one-cycle pulse to the requester whose SHOW period just ended.
- `busy`, output, 1 bit: high while in SHOW.
- `SEG`, output, 8 bits: segment pattern in gfedcba order on `[6:0]`; `SEG[7]` (decimal point) is always 0.

## Operation
- **States:**
  - IDLE: `SEG` = 0x00 (blank), `gnt` = 0.
  - SHOW: `SEG` = glyph of the latched nibble.
- **Registers:** state; `ptr` (priority start index); `idx` (granted index); `nib` (latched nibble); `cnt`; `done`.
- **Reset** (`reset_n` low, immediate, not clock-dependent): state=IDLE, `ptr`=0, `idx`=0, `nib`=0, `cnt`=0. All outputs are 0: `SEG`=0x00, `gnt`=0, `done`=0, `busy`=0.
- **IDLE, no request:** if `req`==0, stay in IDLE; `done` returns to 0.
- **IDLE, request present:** select the first i with `req[i]`=1, scanning `ptr`, `ptr`+1, … modulo `NREQ`. Then:
  - `idx`←i, `nib`←`data[4i+3:4i]`, `cnt`←`HOLD`−1, state←SHOW.
- **SHOW, `cnt`≠0:** `cnt`←`cnt`−1.
- **SHOW, `cnt`==0:** state←IDLE, `done[idx]`←1 for one cycle, `ptr`←(`idx`+1) mod `NREQ`.
- **Glyph map (hex):** 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71.
- **Boundary conditions:**
  - Dropping `req` during SHOW does not abort; the full `HOLD` period is shown.
  - Changes to `data` during SHOW are ignored, because `nib` is latched at grant.
  - `req` still high at `done` is treated as a new request. It is granted only after every other pending requester, since `ptr` has advanced past it.
  - A request that drops before being granted is never granted and never gets `done`.
  - If `req`, `gnt` or `done` are re-asserted in the same cycle as `done`, the arbiter still spends at least one IDLE cycle before the next grant.
  - `ptr` wraps from `NREQ`−1 to 0.
  - `cnt` width is `$clog2(HOLD)`, minimum 1 bit. `HOLD`=1 gives a single SHOW cycle.

## Timing
- **Outputs:** all outputs are registered, or are decoded purely from registered state.
- **Grant latency:** a `req` sampled in IDLE at edge t gives `gnt`/`busy`/`SEG` valid from edge t through edge t+`HOLD`.
- **Done:** `done[idx]` is high for exactly one cycle, starting at edge t+`HOLD`. In that same cycle `SEG` is blank and `gnt`=0.
- **Back-to-back throughput:** one grant per `HOLD`+1 cycles (`HOLD` SHOW + 1 IDLE).
- **Reset release:** the first grant can occur at the first rising edge after `reset_n` deasserts.

## Test plan
- **Reset:** assert `reset_n`=0 mid-SHOW (`gnt`=0010, `SEG`=0x5B). Outputs go 0 immediately, without a clock edge. After release, raise `req`=0011 → requester 0 is granted first (`ptr`=0).
- **Single request** (`HOLD`=4): `req[0]`=1 with `data[3:0]`=A. Expect:
  - `gnt`=0001, `busy`=1, `SEG`=0x77 for 4 cycles.
  - Then `done`=0001 for 1 cycle with `SEG`=0x00.
  - The grant repeats only if `req[0]` is still high.
- **All requesters continuous:** `req`=1111 with nibbles 1, 2, 3, 4. Expect:
  - Grants 0, 1, 2, 3, 0, … every 5 cycles.
  - `SEG` sequence 06, 5B, 4F, 66, each separated by one blank cycle.
- **Round-robin fairness:** after requester 2's `done`, `req`=1001 → requester 3 is granted next, then requester 0.
- **Latching:** during SHOW of requester 1 (nibble F, `SEG`=0x71), change `data[7:4]` to 0 and drop `req[1]`. Expect `SEG` to remain 0x71 for the full `HOLD` and `done[1]` to still pulse.
- **`HOLD`=1:** `req`=0100 held → `gnt` alternates between 0100 and 0 each cycle, and `done[2]` pulses every 2nd cycle.

Source files
------------

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the single 7-segment display: grants one requester,
// latches its nibble, shows the hex glyph for HOLD cycles, then pulses done.
module seg_display_arbiter #(
  parameter int NREQ = 4,
  parameter int HOLD = 4
) (
  input  logic              clk_2,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [7:0]        SEG,
  output logic              dbg_state_o
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SHOW = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [3:0]        nib_q, nib_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   done_q, done_d;

  logic              found;
  logic [IW-1:0]     sel;
  logic [IW-1:0]     cand;
  int unsigned       pos;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      nib_q   <= '0;
      cnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      nib_q   <= nib_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // First pending requester scanning upward from ptr, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr_q) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      cand = IW'(pos);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    nib_d   = nib_q;
    cnt_d   = cnt_q;
    done_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          idx_d   = sel;
          nib_d   = data[{sel, 2'b00} +: 4];
          cnt_d   = CW'(HOLD - 1);
          state_d = S_SHOW;
        end
      end
      default: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d       = S_IDLE;
          done_d[idx_q] = 1'b1;
          ptr_d         = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    gnt         = '0;
    busy        = 1'b0;
    SEG         = 8'h00;
    done        = done_q;
    dbg_state_o = state_q;
    if (state_q == S_SHOW) begin
      gnt[idx_q] = 1'b1;
      busy       = 1'b1;
      SEG        = {1'b0, glyph(nib_q)};
    end
  end

endmodule
